muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_seq_core.sv | 56 +++++
 rtl/muldiv_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Holds the FSM state encoding, funct3 encodings and operand-signedness helpers.
// Imported by muldiv_seq and muldiv_seq_core; no logic of its own.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // MUL is run unsigned: its low half is sign-agnostic, and an unsigned
    // high half lets every MULH* variant be derived from it later.
    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_core.sv
// Iterative datapath: radix-2 shift-add multiply / restoring divide on unsigned magnitudes.
// Latency: one step per 'step' pulse, XLEN steps per operation; 'load' initialises.
// Backpressure: none; fully driven by the sequencer's load/step/div_mode controls.
// Ports: iclk/irst_n clock and async active-low reset; load latches mag_a into the
//        accumulator low half and mag_b as multiplicand/divisor; step advances one
//        iteration in the mode chosen by div_mode; acc is the 2*XLEN accumulator.
module muldiv_seq_core
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic                load,
    input  logic                step,
    input  logic                div_mode,
    input  logic [XLEN-1:0]     mag_a,
    input  logic [XLEN-1:0]     mag_b,
    output logic [2*XLEN-1:0]   acc
);

    logic [XLEN-1:0]   opnd_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;

    // Multiply: acc = {partial high, multiplier}; add on the multiplier LSB,
    // then shift the whole thing right, keeping the carry.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd_b};
    assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}. The shifted remainder can
    // need XLEN+1 bits, so compare at that width. When it is >= divisor the
    // difference is below the divisor and fits in XLEN bits exactly.
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign rem_ge   = (rem_sh >= {1'b0, opnd_b});
    assign rem_sub  = rem_sh[XLEN-1:0] - opnd_b;
    assign div_next = rem_ge ? {rem_sub, acc[XLEN-2:0], 1'b1}
                             : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            acc    <= '0;
            opnd_b <= '0;
        end else if (load) begin
            acc    <= {{XLEN{1'b0}}, mag_a};
            opnd_b <= mag_b;
        end else if (step) begin
            acc    <= div_mode ? div_next : mul_next;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer beside the EX-stage ALU (FSM, counter, signs, special cases).
// Latency: XLEN+2 cycles from accept edge to ovalid; divide-by-zero/overflow (and fused hits) 1 cycle.
// Backpressure: ostall holds the pipeline while ivalid && !ovalid; accepts only in IDLE (oready).
// Ports: iclk/irst_n; ivalid/ifunct3/isrc_a/isrc_b request; iflush abort;
//        oready (IDLE), ovalid one-cycle strobe with oresult, ostall to the hazard unit.
// Optional: define MULDIV_FUSE_EN to reuse the last DIV/REM pair or MUL high half.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            iclk,
    input  logic            irst_n,
    input  logic            ivalid,
    input  logic [2:0]      ifunct3,
    input  logic [XLEN-1:0] isrc_a,
    input  logic [XLEN-1:0] isrc_b,
    input  logic            iflush,
    output logic            oready,
    output logic            ovalid,
    output logic [XLEN-1:0] oresult,
    output logic            ostall
);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         f3_q;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder takes the dividend's sign

    logic               neg_a, neg_b;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic               div_zero, div_ovf, special;
    logic [XLEN-1:0]    special_val;
    logic               accept, core_load, core_step;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quot, rem;
    logic [XLEN-1:0]    fix_val;
    logic               fuse_hit;
    logic [XLEN-1:0]    fuse_val;

    assign neg_a = signed_a(ifunct3) & isrc_a[XLEN-1];
    assign neg_b = signed_b(ifunct3) & isrc_b[XLEN-1];
    assign mag_a = neg_a ? -isrc_a : isrc_a;
    assign mag_b = neg_b ? -isrc_b : isrc_b;

    assign div_zero = ifunct3[2] & (isrc_b == '0);
    assign div_ovf  = ifunct3[2] & ~ifunct3[0] & (isrc_a == INT_MIN) & (isrc_b == ALL_ONES);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = ifunct3[1] ? isrc_a : ALL_ONES;
        else
            special_val = ifunct3[1] ? '0 : INT_MIN;
    end

    assign accept    = (state == ST_IDLE) & ivalid & ~iflush;
    assign core_load = accept & ~special & ~fuse_hit;
    assign core_step = (state == ST_CALC) & ~iflush;

    // The result strobe is registered, so a stall release never depends on a
    // long combinational path; only ivalid/iflush gate it combinationally.
    assign ostall = ivalid & ~ovalid & ~iflush;

    muldiv_seq_core #(.XLEN(XLEN)) u_core (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .load     (core_load),
        .step     (core_step),
        .div_mode (f3_q[2]),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .acc      (acc)
    );

    assign prod = neg_res ? -acc : acc;
    assign quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = '0;
        case (f3_q)
            F3_MUL:                       fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = quot;
            default:                      fix_val = rem;
        endcase
    end

`ifdef MULDIV_FUSE_EN
    logic            c_vld;
    logic [2:0]      c_f3;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r;
    logic [XLEN-1:0] a_q, b_q;
    logic            same_ops, div_hit, mul_hit;
    logic [XLEN-1:0] corr_a, corr_b;

    assign same_ops = c_vld & (isrc_a == c_a) & (isrc_b == c_b);
    // DIV<->REM with matching signedness reuses the other half of the pair.
    assign div_hit  = same_ops & c_f3[2] & ifunct3[2] &
                      (ifunct3[0] == c_f3[0]) & (ifunct3[1] != c_f3[1]);
    assign mul_hit  = same_ops & (c_f3 == F3_MUL) & ~ifunct3[2] & (ifunct3 != F3_MUL);
    assign fuse_hit = div_hit | mul_hit;

    // The cached MUL high half is unsigned; signed variants subtract the
    // cross terms contributed by a negative operand.
    assign corr_a = isrc_a[XLEN-1] ? isrc_b : '0;
    assign corr_b = isrc_b[XLEN-1] ? isrc_a : '0;

    always_comb begin
        fuse_val = '0;
        if (div_hit)
            fuse_val = ifunct3[1] ? c_r : c_q;
        else if (ifunct3 == F3_MULHU)
            fuse_val = c_q;
        else if (ifunct3 == F3_MULHSU)
            fuse_val = c_q - corr_a;
        else
            fuse_val = c_q - corr_a - corr_b;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            c_vld <= 1'b0;
            c_f3  <= '0;
            c_a   <= '0;
            c_b   <= '0;
            c_q   <= '0;
            c_r   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            if (accept) begin
                a_q <= isrc_a;
                b_q <= isrc_b;
            end
            if (iflush) begin
                c_vld <= 1'b0;
            end else if (accept & ~fuse_hit) begin
                c_vld <= 1'b0;
            end else if ((state == ST_FIX) && (f3_q[2] || (f3_q == F3_MUL))) begin
                c_vld <= 1'b1;
                c_f3  <= f3_q;
                c_a   <= a_q;
                c_b   <= b_q;
                c_q   <= f3_q[2] ? quot : acc[2*XLEN-1:XLEN];
                c_r   <= f3_q[2] ? rem : '0;
            end
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_val = '0;
`endif

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            f3_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            oready  <= 1'b1;
            ovalid  <= 1'b0;
            oresult <= '0;
        end else begin
            ovalid <= 1'b0;
            if (iflush) begin
                // A result already registered this cycle still goes out;
                // anything in flight is dropped and oresult keeps its value.
                state  <= ST_IDLE;
                oready <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ivalid) begin
                            f3_q    <= ifunct3;
                            neg_res <= neg_a ^ neg_b;
                            neg_rem <= neg_a;
                            oready  <= 1'b0;
                            if (fuse_hit || special) begin
                                oresult <= fuse_hit ? fuse_val : special_val;
                                ovalid  <= 1'b1;
                                state   <= ST_DONE;
                            end else begin
                                cnt   <= CNT_W'(XLEN);
                                state <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        oresult <= fix_val;
                        ovalid  <= 1'b1;
                        state   <= ST_DONE;
                    end
                    ST_DONE: begin
                        // Never accept here: ivalid still belongs to the
                        // instruction that just completed.
                        state  <= ST_IDLE;
                        oready <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        ivalid = 1'b0;
    logic [2:0]  ifunct3 = 3'd0;
    logic [31:0] isrc_a = 32'd0;
    logic [31:0] isrc_b = 32'd0;
    logic        iflush = 1'b0;
    logic        oready;
    logic        ovalid;
    logic [31:0] oresult;
    logic        ostall;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .ivalid  (ivalid),
        .ifunct3 (ifunct3),
        .isrc_a  (isrc_a),
        .isrc_b  (isrc_b),
        .iflush  (iflush),
        .oready  (oready),
        .ovalid  (ovalid),
        .oresult (oresult),
        .ostall  (ostall)
    );

    always #5 iclk = ~iclk;

`ifdef MULDIV_FUSE_EN
    localparam int FUSE_LAT = 1;
`else
    localparam int FUSE_LAT = 34;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_res = 32'd0;

    // reference reuse cache (only consulted when the feature is built in)
    logic        m_vld = 1'b0;
    logic [2:0]  m_f   = 3'd0;
    logic [31:0] m_a   = 32'd0;
    logic [31:0] m_b   = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic bit fuse_hit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FUSE_EN
        if (!m_vld || a != m_a || b != m_b) return 1'b0;
        if (m_f[2] && f[2]) return (f[0] == m_f[0]) && (f[1] != m_f[1]);
        return (m_f == 3'd0) && (f != 3'd0) && !f[2];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (fuse_hit(f, a, b) || is_special(f, a, b)) ? 1 : 34;
    endfunction

    // Drive one op, hold ivalid until the result strobe, score result/latency/stall.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          cyc;
        int          stalls;
        bit          hit;
        bit          spec;
        logic [31:0] e;
        int          l;
        @(negedge iclk);
        check({tag, "_rdy"}, {31'd0, oready}, 32'd1);
        hit  = fuse_hit(f, a, b);
        spec = is_special(f, a, b);
        ivalid  = 1'b1;
        ifunct3 = f;
        isrc_a  = a;
        isrc_b  = b;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        #1;
        stalls = ostall ? 1 : 0;
        cyc = 0;
        while (!ovalid && cyc < 200) begin
            @(negedge iclk);
            cyc++;
            if (ostall) stalls++;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        if (!ovalid) begin
            check({tag, "_timeout"}, {31'd0, ovalid}, 32'd1);
        end else begin
            check(tag, oresult, e);
            check({tag, "_lat"}, cyc, l);
            check({tag, "_stall"}, stalls, l);
            last_res = e;
        end
        ivalid = 1'b0;
        if (!hit) begin
            if (!spec && (f[2] || f == 3'd0)) begin
                m_vld = 1'b1; m_f = f; m_a = a; m_b = b;
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        run_op(tag, f, a, b, exp, exp_lat(f, a, b));
    endtask

    // flush while idle with ivalid high must not accept
    task automatic flush_idle(input string tag);
        @(negedge iclk);
        ivalid  = 1'b1;
        ifunct3 = 3'd0;
        iflush  = 1'b1;
        #1;
        check({tag, "_stall"}, {31'd0, ostall}, 32'd0);
        @(negedge iclk);
        ivalid = 1'b0;
        iflush = 1'b0;
        check({tag, "_rdy"}, {31'd0, oready}, 32'd1);
        m_vld = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nval;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        repeat (3) @(negedge iclk);
        check("rst_rdy",   {31'd0, oready}, 32'd1);
        check("rst_vld",   {31'd0, ovalid}, 32'd0);
        check("rst_res",   oresult,         32'd0);
        check("rst_stall", {31'd0, ostall}, 32'd0);
        irst_n = 1'b1;

        op("mul_7x-3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        op("mulhu_ff",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op("mulhsu_ff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op("mulh_ff",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        op("div_-7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        op("rem_-7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        op("divu_100_7", 3'd5, 32'd100,        32'd7,         32'd14);
        op("remu_100_7", 3'd7, 32'd100,        32'd7,         32'd2);
        op("div_x_0",    3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF);
        op("remu_5_0",   3'd7, 32'd5,          32'd0,         32'd5);
        op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

        flush_idle("flush_idle");

        // abort a divide in the middle of its iterations
        @(negedge iclk);
        ivalid  = 1'b1;
        ifunct3 = 3'd5;
        isrc_a  = 32'd1000;
        isrc_b  = 32'd3;
        repeat (11) @(negedge iclk);
        iflush = 1'b1;
        ivalid = 1'b0;
        #1;
        check("flush_stall", {31'd0, ostall}, 32'd0);
        @(negedge iclk);
        iflush = 1'b0;
        m_vld  = 1'b0;
        check("flush_rdy", {31'd0, oready}, 32'd1);
        nval = 0;
        repeat (40) begin
            @(negedge iclk);
            if (ovalid) nval++;
        end
        check("flush_noval", nval, 32'd0);
        check("flush_hold", oresult, last_res);
        op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, model(rf, ra, rb));
        end

        // reuse of the pair partner / cached high half
        run_op("fuse_div",    3'd4, 32'd100, 32'd7, 32'd14, 34);
        run_op("fuse_rem",    3'd6, 32'd100, 32'd7, 32'd2,  FUSE_LAT);
        run_op("fuse_div2",   3'd4, 32'd100, 32'd7, 32'd14, 34);
        flush_idle("fuse_flush");
        run_op("fuse_rem_fl", 3'd6, 32'd100, 32'd7, 32'd2,  34);
        run_op("fuse_mul",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        run_op("fuse_mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FUSE_LAT);
        run_op("fuse_mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, FUSE_LAT);
        run_op("fuse_mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FUSE_LAT);

        // asynchronous reset in the middle of a multiply
        @(negedge iclk);
        ivalid  = 1'b1;
        ifunct3 = 3'd0;
        isrc_a  = 32'd12345;
        isrc_b  = 32'd678;
        repeat (5) @(negedge iclk);
        ivalid = 1'b0;
        #2;
        irst_n = 1'b0;
        #1;
        check("arst_rdy", {31'd0, oready}, 32'd1);
        check("arst_vld", {31'd0, ovalid}, 32'd0);
        check("arst_res", oresult,         32'd0);
        @(negedge iclk);
        irst_n   = 1'b1;
        m_vld    = 1'b0;
        last_res = 32'd0;
        op("post_rst_mul", 3'd0, 32'd12345, 32'd678, 32'd8369910);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
